// File: rtl/mux153_arbiter.sv
// Round-robin owner arbiter driving a dual 4:1 mux.
// Break-before-make GAP cycle between owners, burst-limited.
module mux153_arbiter #(
  parameter int unsigned BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] A,
  output logic       _S1,
  output logic       _S2,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    OWN
  } state_t;

  localparam logic [3:0] CNT_MAX = 4'(BURST - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [1:0] last_owner;

  logic [3:0] others;
  logic       owner_req;
  logic       any_req;
  logic       any_other;
  logic [1:0] rr_all;
  logic [1:0] rr_oth;

  // First set bit searching upward from last+1, wrapping.
  function automatic logic [1:0] rr_pick(
    input logic [3:0] r,
    input logic [1:0] last
  );
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Request views relative to the last owner.
  always_comb begin
    others    = req & ~(4'b0001 << last_owner);
    owner_req = req[last_owner];
    any_req   = |req;
    any_other = |others;
    rr_all    = rr_pick(req, last_owner);
    rr_oth    = rr_pick(others, last_owner);
  end

  // Arbiter FSM; every output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= 4'b0000;
      A          <= 2'd0;
      _S1        <= 1'b1;
      _S2        <= 1'b1;
      busy       <= 1'b0;
      cnt        <= 4'd0;
      last_owner <= 2'd3;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state <= GAP;
            A     <= rr_all;
            busy  <= 1'b1;
          end
        end
        GAP: begin
          if (req[A]) begin
            state      <= OWN;
            gnt        <= 4'b0001 << A;
            _S1        <= 1'b0;
            _S2        <= 1'b0;
            last_owner <= A;
            cnt        <= 4'd0;
          end else if (any_req) begin
            A <= rr_all;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        OWN: begin
          if (!owner_req) begin
            gnt <= 4'b0000;
            _S1 <= 1'b1;
            _S2 <= 1'b1;
            if (any_other) begin
              state <= GAP;
              A     <= rr_oth;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (cnt == CNT_MAX && any_other) begin
            gnt   <= 4'b0000;
            _S1   <= 1'b1;
            _S2   <= 1'b1;
            state <= GAP;
            A     <= rr_oth;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'b0000;
          _S1   <= 1'b1;
          _S2   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux153_arbiter.sv
// Bench for mux153_arbiter: spec-level model compared every
// negedge, plus directed literal expectations.
module tb_mux153_arbiter;

  localparam int B = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] a;
  logic       s1;
  logic       s2;
  logic       busy;

  int errors = 0;
  int checks = 0;

  mux153_arbiter #(.BURST(B)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .gnt  (gnt),
    .A    (a),
    ._S1  (s1),
    ._S2  (s2),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = idle, 1 = gap, 2 = owning
  int m_phase;
  int m_sel;
  int m_owner;
  int m_held;

  // Requester nearest after 'last' in circular order.
  function automatic int nearest(input logic [3:0] r, input int last);
    int best;
    int bd;
    int d;
    best = last;
    bd   = 99;
    for (int i = 0; i < 4; i++) begin
      d = (i - last + 3) % 4;
      if (r[i] && d < bd) begin
        bd   = d;
        best = i;
      end
    end
    return best;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [3:0] oth;
    if (!rst_n) begin
      m_phase = 0;
      m_sel   = 0;
      m_owner = 3;
      m_held  = 0;
    end else begin
      oth = req;
      oth[m_owner] = 1'b0;
      if (m_phase == 0) begin
        if (req != 0) begin
          m_sel   = nearest(req, m_owner);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (req[m_sel]) begin
          m_phase = 2;
          m_owner = m_sel;
          m_held  = 1;
        end else if (req != 0) begin
          m_sel = nearest(req, m_owner);
        end else begin
          m_phase = 0;
        end
      end else begin
        if (!req[m_owner] || (m_held >= B && oth != 0)) begin
          if (oth != 0) begin
            m_sel   = nearest(oth, m_owner);
            m_phase = 1;
          end else begin
            m_phase = 0;
          end
        end else begin
          m_held++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [1:0] prev_a;
  logic       prev_s1;
  initial begin
    prev_a  = 2'd0;
    prev_s1 = 1'b1;
  end

  always @(negedge clk) begin
    int eg;
    eg = (m_phase == 2) ? (1 << m_owner) : 0;
    check("model_gnt", int'(gnt), eg);
    check("model_a", int'(a), m_sel);
    check("model_s1", int'(s1), (m_phase == 2) ? 0 : 1);
    check("model_busy", int'(busy), (m_phase != 0) ? 1 : 0);
    check("s2_eq_s1", int'(s2), int'(s1));
    check("gnt_onehot0", int'($onehot0(gnt)), 1);
    if (!prev_s1 && !s1) check("a_stable_own", int'(a), int'(prev_a));
    prev_a  = a;
    prev_s1 = s1;
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int own_seq [4];
    own_seq = '{1, 2, 3, 0};
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (3) @(posedge clk);
    #3;
    check("rst_gnt", int'(gnt), 0);
    check("rst_a", int'(a), 0);
    check("rst_s1", int'(s1), 1);
    check("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // single requester 0
    req = 4'b0001;
    cyc();
    check("r29_gap_gnt", int'(gnt), 0);
    check("r29_gap_a", int'(a), 0);
    check("r29_gap_busy", int'(busy), 1);
    cyc();
    check("r29_gnt", int'(gnt), 1);
    check("r29_s1", int'(s1), 0);
    check("r29_s2", int'(s2), 0);
    repeat (6) cyc();
    check("r29_hold", int'(gnt), 1);

    // all requesting: rotation 1,2,3,0 with 4 owned cycles each
    req = 4'b1111;
    foreach (own_seq[k]) begin
      cyc();
      check("r30_gap_gnt", int'(gnt), 0);
      check("r30_gap_a", int'(a), own_seq[k]);
      for (int c = 0; c < 4; c++) begin
        cyc();
        check("r30_own", int'(gnt), 1 << own_seq[k]);
      end
    end

    // owner 0 drops, 2 pending; then 2 drops with 3 pending
    req = 4'b0100;
    cyc();
    check("r31_gap_a2", int'(a), 2);
    cyc();
    check("r31_gnt2", int'(gnt), 4);
    cyc();
    req = 4'b1000;
    cyc();
    check("r31_gap_a3", int'(a), 3);
    check("r31_gap_gnt", int'(gnt), 0);
    cyc();
    check("r31_gnt3", int'(gnt), 8);
    req = 4'b0000;
    cyc();
    check("r31_idle_busy", int'(busy), 0);
    check("r31_idle_gnt", int'(gnt), 0);
    check("r31_idle_a", int'(a), 3);

    // lone requester 1 for 20 cycles, no GAP after grant
    req = 4'b0010;
    cyc();
    check("r32_gap_a", int'(a), 1);
    for (int c = 0; c < 20; c++) begin
      cyc();
      check("r32_gnt", int'(gnt), 2);
    end
    req = 4'b0000;
    cyc();

    // requester 3 vanishes during GAP, 0 takes over
    req = 4'b1000;
    cyc();
    check("r33_gap_a3", int'(a), 3);
    req = 4'b0001;
    cyc();
    check("r33_regap_a", int'(a), 0);
    check("r33_regap_gnt", int'(gnt), 0);
    cyc();
    check("r33_gnt0", int'(gnt), 1);

    // asynchronous reset mid-OWN
    cyc();
    rst_n = 1'b0;
    #1;
    check("r34_gnt", int'(gnt), 0);
    check("r34_a", int'(a), 0);
    check("r34_s1", int'(s1), 1);
    check("r34_s2", int'(s2), 1);
    check("r34_busy", int'(busy), 0);
    req = 4'b1100;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    check("r34_gap_a", int'(a), 2);
    cyc();
    check("r34_gnt2", int'(gnt), 4);
    req = 4'b0000;
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mux153_arbiter.md
MUX153_ARBITER -- requirements
Module: mux153_arbiter

Interface
REQ-001 Parameter BURST, default 4, maximum consecutive owned cycles before forced rotation when others are waiting; legal 1..15.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req  input  4  per-requester request for the dual 4:1 mux; bit i = requester i.
REQ-005 gnt  output  4  one-hot grant; all-zero when no owner.
REQ-006 A  output  2  mux select; equals index of current or pending owner.
REQ-007 _S1  output  1  active-low strobe for mux section 1.
REQ-008 _S2  output  1  active-low strobe for mux section 2; always equal to _S1.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 All outputs SHALL be registered; no combinational path from req to any output.

Function
REQ-011 FSM states SHALL be IDLE, GAP, OWN.
REQ-012 IDLE: gnt=0, _S1=_S2=1, A holds last value; if any req bit is sampled high, compute winner, load A=winner, go to GAP.
REQ-013 Winner SHALL be chosen round-robin: search starts at (last_owner+1) mod 4, wraps, picks first set req bit.
REQ-014 GAP (break-before-make, exactly one cycle per evaluation): gnt=0, _S1=_S2=1, A=winner.
REQ-015 GAP exit: if req[winner] high -> OWN with gnt=onehot(winner), _S1=_S2=0, last_owner=winner, cnt=0.
REQ-016 GAP exit: if req[winner] low but another req bit high -> stay in GAP, recompute winner from the same round-robin pointer, and update A.
REQ-017 GAP exit: if req=0 -> IDLE.
REQ-018 Latency: req sampled high in IDLE at edge k -> GAP after edge k -> gnt/strobes asserted after edge k+1.
REQ-019 OWN: cnt increments each cycle and saturates at BURST-1.
REQ-020 OWN: if req[owner] is sampled low -> release; go to GAP if any other req is set, else to IDLE.
REQ-021 OWN: if cnt==BURST-1 and any other req bit is set -> forced rotation to GAP with winner chosen excluding the owner.
REQ-022 OWN: if cnt==BURST-1 and no other req is set -> remain in OWN, grant unchanged, cnt held.
REQ-023 Simultaneous owner drop and burst expiry SHALL be treated as a release (REQ-020).
REQ-024 A SHALL change only on entry to GAP; never while _S1/_S2 are low.
REQ-025 gnt SHALL never have more than one bit set.
REQ-026 With BURST=1, every OWN cycle with a competing requester SHALL rotate: at most one owned cycle per GAP.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, gnt=0, A=0, _S1=_S2=1, busy=0, cnt=0, last_owner=3, regardless of the current state, including mid-OWN.
REQ-028 After rst_n deasserts, the first grant SHALL go to the lowest-index set requester.

Verification
REQ-029 Reset, then req=0001 -> GAP with A=0 after 1 cycle; gnt=0001, _S1=_S2=0 after 2 cycles; held while req[0]=1.
REQ-030 req=1111 continuously, BURST=4 -> owners 0,1,2,3,0...; each owns exactly 4 cycles with one GAP cycle between; A changes only in GAP.
REQ-031 Owner 2 drops req after 2 cycles with req[3] pending -> GAP, then gnt=1000; with no other req pending -> IDLE, busy=0.
REQ-032 Single requester 1 held for 20 cycles, BURST=4 -> gnt=0010 throughout with no GAP.
REQ-033 Requester 3 raises req then drops it during GAP while req[0] is set -> GAP repeats with A=0, then gnt=0001.
REQ-034 rst_n pulsed low mid-OWN -> outputs immediately return to gnt=0, _S1=_S2=1, A=0; next grant goes to the lowest set req.
